// File: rtl/secure_mem_loader_if.sv
// Host word stream plus data-memory write port of the secure loader.
// Latency: none, plain signal bundle.
// Backpressure: host side is valid/ready; the memory side has no backpressure.
//
// Signals:
//   host_valid / host_data / host_ready : host word handshake
//   data_in / write_address / wenable   : memory write port
// Modports: master = host and memory side, slave = the loader.
interface secure_mem_loader_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              host_valid;
   logic [DATA_W-1:0] host_data;
   logic              host_ready;
   logic [DATA_W-1:0] data_in;
   logic [ADDR_W-1:0] write_address;
   logic              wenable;

   modport master (
      output host_valid, host_data,
      input  host_ready, data_in, write_address, wenable
   );

   modport slave (
      input  host_valid, host_data,
      output host_ready, data_in, write_address, wenable
   );
endinterface

// File: rtl/secure_mem_loader.sv
// Key-gated loader: buffers host words in a small FIFO and writes them to data memory.
// Latency: a word accepted at edge N is on the memory port after edge N+1; one word per cycle sustained.
// Backpressure: host_ready drops when the FIFO is full or all words of the transfer are accepted.
//
// Ports:
//   clk, reset (async, active low)
//   start, base_addr, word_count : transfer request, sampled when idle or faulted
//   bus (slave)                  : host handshake in, memory write port out
//   busy, done, key_fault        : status (busy in UNLOCK/LOAD, done pulse, sticky key fault)
module secure_mem_loader #(
   parameter int                DATA_W     = 32,
   parameter int                ADDR_W     = 5,
   parameter int                FIFO_DEPTH = 4,
   parameter logic [DATA_W-1:0] UNLOCK_KEY = 32'hA5C3_0F1E
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [ADDR_W-1:0]  base_addr,
   input  logic [ADDR_W:0]    word_count,
   secure_mem_loader_if.slave bus,
   output logic               busy,
   output logic               done,
   output logic               key_fault
);
   localparam int               PTR_W    = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]   OCC_FULL = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [ADDR_W:0]  CNT_ONE  = (ADDR_W+1)'(1);

   typedef enum logic [2:0] {S_IDLE, S_UNLOCK, S_LOAD, S_DONE, S_FAULT} state_t;

   state_t            state;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W:0]   count_q;
   logic [ADDR_W:0]   accepted;
   logic [ADDR_W:0]   written;

   logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    occ;

   logic fifo_full;
   logic fifo_empty;
   logic host_ready;
   logic push;
   logic pop;

   always_comb begin
      fifo_full  = (occ == OCC_FULL);
      fifo_empty = (occ == '0);
      // The key word is accepted in UNLOCK but never enters the FIFO.
      host_ready = (state == S_UNLOCK) ||
                   ((state == S_LOAD) && !fifo_full && (accepted < count_q));
      push       = (state == S_LOAD) && bus.host_valid && host_ready;
      pop        = (state == S_LOAD) && !fifo_empty && (written != count_q);
      busy       = (state == S_UNLOCK) || (state == S_LOAD);
      done       = (state == S_DONE);
      // FAULT is left only by start, which is exactly when the fault clears.
      key_fault  = (state == S_FAULT);
   end

   assign bus.host_ready = host_ready;

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= bus.host_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state             <= S_IDLE;
         base_q            <= '0;
         count_q           <= '0;
         accepted          <= '0;
         written           <= '0;
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         occ               <= '0;
         bus.data_in       <= '0;
         bus.write_address <= '0;
         bus.wenable       <= 1'b0;
      end else begin
         bus.wenable <= 1'b0;

         if (push) begin
            wr_ptr   <= wr_ptr + PTR_ONE;
            accepted <= accepted + CNT_ONE;
         end

         if (pop) begin
            rd_ptr            <= rd_ptr + PTR_ONE;
            bus.data_in       <= fifo_mem[rd_ptr];
            // Address wraps modulo the memory size by truncation.
            bus.write_address <= base_q + written[ADDR_W-1:0];
            bus.wenable       <= 1'b1;
            written           <= written + CNT_ONE;
         end

         case ({push, pop})
            2'b10:   occ <= occ + OCC_ONE;
            2'b01:   occ <= occ - OCC_ONE;
            default: occ <= occ;
         endcase

         case (state)
            S_IDLE, S_FAULT: begin
               if (start) begin
                  base_q   <= base_addr;
                  count_q  <= word_count;
                  accepted <= '0;
                  written  <= '0;
                  wr_ptr   <= '0;
                  rd_ptr   <= '0;
                  occ      <= '0;
                  state    <= S_UNLOCK;
               end
            end
            S_UNLOCK: begin
               if (bus.host_valid) begin
                  if (bus.host_data != UNLOCK_KEY) begin
                     state <= S_FAULT;
                  end else if (count_q == '0) begin
                     state <= S_DONE;
                  end else begin
                     state <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               // written == count_q means the final write is on the port this cycle.
               if (written == count_q) begin
                  state <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_secure_mem_loader.sv
module tb_secure_mem_loader;
   localparam int          DATA_W = 32;
   localparam int          ADDR_W = 5;
   localparam logic [31:0] KEY    = 32'hA5C3_0F1E;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   logic              clk        = 1'b0;
   logic              reset      = 1'b0;
   logic              start      = 1'b0;
   logic [ADDR_W-1:0] base_addr  = '0;
   logic [ADDR_W:0]   word_count = '0;
   logic              busy;
   logic              done;
   logic              key_fault;

   secure_mem_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   secure_mem_loader #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(4), .UNLOCK_KEY(KEY)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .word_count(word_count), .bus(bus), .busy(busy), .done(done),
      .key_fault(key_fault)
   );

   always #5 clk = ~clk;

   wr_t exp_q[$];
   int  vectors      = 0;
   int  miscompares  = 0;
   int  wr_seen      = 0;
   int  done_seen    = 0;
   int  cyc_n        = 0;
   int  run_len      = 0;
   int  max_run      = 0;
   int  last_wen_cyc = 0;
   int  done_cyc     = 0;

   // Monitor: every memory write is matched against the scoreboard.
   always @(negedge clk) begin
      cyc_n++;
      if (reset === 1'b1 && bus.wenable === 1'b1) begin
         wr_seen++;
         run_len++;
         if (run_len > max_run) max_run = run_len;
         last_wen_cyc = cyc_n;
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                     bus.write_address, bus.data_in);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (e.addr !== bus.write_address || e.data !== bus.data_in) begin
               miscompares++;
               $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                        bus.write_address, bus.data_in, e.addr, e.data);
            end
         end
      end else begin
         run_len = 0;
      end
      if (reset === 1'b1 && done === 1'b1) begin
         done_seen++;
         done_cyc = cyc_n;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int k);
      bus.host_valid = 1'b0;
      bus.host_data  = $urandom;
      repeat (k) tick();
   endtask

   task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c);
      base_addr  = b;
      word_count = c;
      start      = 1'b1;
      tick();
      start      = 1'b0;
      base_addr  = ADDR_W'($urandom);
      word_count = (ADDR_W+1)'($urandom);
   endtask

   // Presents one word and returns just after the edge on which it was taken.
   task automatic send_word(input logic [DATA_W-1:0] d);
      logic rdy;
      int   n;
      n = 0;
      bus.host_valid = 1'b1;
      bus.host_data  = d;
      forever begin
         @(negedge clk);
         rdy = bus.host_ready;
         tick();
         if (rdy) break;
         n++;
         if (n > 100) begin
            vectors++;
            miscompares++;
            $display("FAIL handshake_timeout: host_ready got 0 for 100 cycles, required 1");
            break;
         end
      end
      bus.host_valid = 1'b0;
      bus.host_data  = $urandom;
   endtask

   task automatic wait_done(input int d0);
      for (int n = 0; n < 200; n++) begin
         if (done_seen > d0) break;
         tick();
      end
      repeat (3) tick();
      check("done_pulse_count", 64'(done_seen - d0), 64'd1);
   endtask

   task automatic run_xfer(input logic [ADDR_W-1:0] base, input logic [DATA_W-1:0] dq[$],
                           input bit gaps);
      int n;
      int d0;
      n  = dq.size();
      d0 = done_seen;
      for (int i = 0; i < n; i++)
         exp_q.push_back('{addr: ADDR_W'(int'(base) + i), data: dq[i]});
      do_start(base, (ADDR_W+1)'(n));
      check("busy_after_start", busy, 1);
      check("key_fault_cleared", key_fault, 0);
      send_word(KEY);
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
         send_word(dq[i]);
      end
      // Extra words must be refused once the transfer has all its data.
      bus.host_valid = 1'b1;
      bus.host_data  = $urandom;
      @(negedge clk);
      #1;
      check("host_ready_after_last", bus.host_ready, 0);
      tick();
      bus.host_valid = 1'b0;
      wait_done(d0);
      check("all_writes_seen", 64'(exp_q.size()), 64'd0);
      check("busy_after_done", busy, 0);
   endtask

   task automatic bad_key();
      int          d0;
      logic [31:0] w;
      d0 = done_seen;
      w  = $urandom;
      if (w == KEY) w = w ^ 32'h1;
      do_start(ADDR_W'($urandom), (ADDR_W+1)'($urandom_range(1, 10)));
      send_word(w);
      bus.host_valid = 1'b1;
      bus.host_data  = $urandom;
      repeat (3) tick();
      check("bad_key_fault", key_fault, 1);
      check("bad_key_ready", bus.host_ready, 0);
      check("bad_key_busy", busy, 0);
      check("bad_key_no_done", 64'(done_seen), 64'(d0));
      bus.host_valid = 1'b0;
   endtask

   function automatic void rand_data(input int n, output logic [DATA_W-1:0] q[$]);
      q = {};
      for (int i = 0; i < n; i++) q.push_back($urandom);
   endfunction

   initial begin
      logic [DATA_W-1:0] dq[$];
      int                d0;
      int                w0;
      bus.host_valid = 1'b0;
      bus.host_data  = '0;
      #1;
      check("rst_outputs",
            {62'd0, bus.host_ready, bus.wenable},
            64'd0);
      check("rst_status", {61'd0, busy, done, key_fault}, 64'd0);
      check("rst_data_addr", {27'd0, bus.write_address, bus.data_in}, 64'd0);
      #20;
      reset = 1'b1;
      tick();

      // Basic load.
      dq = '{32'h11, 32'h22, 32'h33};
      run_xfer(5'd4, dq, 1'b0);

      // Wrong key, then a correct transfer.
      bad_key();
      dq = '{32'hCAFE_0001, 32'hCAFE_0002};
      run_xfer(5'd12, dq, 1'b0);

      // Backpressure gaps and address wrap.
      rand_data(6, dq);
      run_xfer(5'd30, dq, 1'b1);

      // Zero length: done one cycle after the key.
      d0 = done_seen;
      do_start(5'd9, '0);
      send_word(KEY);
      check("zero_len_done", done, 1);
      check("zero_len_no_wen", bus.wenable, 0);
      tick();
      check("zero_len_done_cleared", done, 0);
      check("zero_len_done_count", 64'(done_seen), 64'(d0 + 1));

      // Reset after two of five words written.
      w0 = wr_seen;
      rand_data(5, dq);
      for (int i = 0; i < 5; i++) exp_q.push_back('{addr: ADDR_W'(10 + i), data: dq[i]});
      do_start(5'd10, 6'd5);
      send_word(KEY);
      send_word(dq[0]);
      send_word(dq[1]);
      send_word(dq[2]);
      @(negedge clk);
      #1;
      check("mid_reset_writes_before", 64'(wr_seen - w0), 64'd2);
      reset = 1'b0;
      #1;
      check("mid_reset_outputs",
            {59'd0, bus.host_ready, bus.wenable, busy, done, key_fault}, 64'd0);
      check("mid_reset_data_addr", {27'd0, bus.write_address, bus.data_in}, 64'd0);
      check("mid_reset_pending", 64'(exp_q.size()), 64'd3);
      exp_q.delete();
      repeat (2) tick();
      reset = 1'b1;
      w0 = wr_seen;
      repeat (10) tick();
      check("post_reset_no_writes", 64'(wr_seen), 64'(w0));
      check("post_reset_idle", {62'd0, busy, bus.host_ready}, 64'd0);

      // Full-rate 32-word transfer.
      rand_data(32, dq);
      max_run = 0;
      run_xfer(5'd7, dq, 1'b0);
      check("full_rate_run", 64'(max_run), 64'd32);
      check("done_after_last_write", 64'(done_cyc - last_wen_cyc), 64'd1);

      // Randomized mix.
      for (int t = 0; t < 12; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            bad_key();
         end else begin
            rand_data($urandom_range(1, 12), dq);
            run_xfer(ADDR_W'($urandom), dq, 1'b1);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at time limit, required completion");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1);
   end
endmodule

// File: doc/secure_mem_loader.md
Name: secure_mem_loader

Overview:
- Host-side load stage directly upstream of the processor's data memory.
- Accepts a stream of 32-bit words from an external host over a valid/ready handshake and buffers them in a small FIFO.
- Drives the memory write port (data_in, write_address, wenable) one word per cycle.
- Refuses the transfer unless the first host word matches a fixed unlock key, so memory cannot be preloaded without the key.

Parameters:
DATA_W, 32, width of host and memory data words
ADDR_W, 5, memory address width (32-word memory)
FIFO_DEPTH, 4, buffer entries (power of two, >=2)
UNLOCK_KEY, 32'hA5C3_0F1E, required first word of every transfer

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins a transfer
base_addr  input  ADDR_W  first memory address, sampled on start
word_count  input  ADDR_W+1  number of data words (0..2^ADDR_W), sampled on start
host_valid  input  1  host word valid
host_data  input  DATA_W  host word
host_ready  output  1  loader accepts host word this cycle
data_in  output  DATA_W  memory write data
write_address  output  ADDR_W  memory write address
wenable  output  1  memory write strobe
busy  output  1  high in UNLOCK and LOAD
done  output  1  one-cycle pulse at transfer end
key_fault  output  1  sticky; wrong key received

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; FIFO emptied; all counters 0; host_ready, wenable, busy, done, key_fault = 0; data_in and write_address = 0. Reset mid-transfer aborts with no further writes.
- Handshake: a word transfers on a rising edge where host_valid && host_ready. host_data must be ignored when host_ready=0.
- States:
  - IDLE: host_ready=0. On start, latch base_addr/word_count, clear counters and key_fault, go to UNLOCK.
  - FAULT: host_ready=0, key_fault=1. Exits only on start (same action as from IDLE).
  - UNLOCK: host_ready=1. The accepted word is compared with UNLOCK_KEY and never written to memory. On match: go to LOAD, or to DONE if word_count=0. On mismatch: go to FAULT.
  - LOAD: the data phase (see below).
  - DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored in UNLOCK, LOAD and DONE.
- LOAD, accept side:
  - host_ready = !fifo_full && (accepted < word_count).
  - Each accepted word is pushed to the FIFO.
- LOAD, write side:
  - Whenever the FIFO is non-empty, pop one word per cycle and register it to data_in.
  - write_address = (base_addr + written) mod 2^ADDR_W; the address wraps, it does not saturate.
  - wenable=1 for that cycle; written increments.
- Latency: a word accepted at edge N has wenable high in the cycle after edge N+1 at the earliest. Throughput is one word per cycle sustained.
- Push and pop in the same cycle are legal; occupancy is unchanged. When full, host_ready=0, so there is no overflow. Pop on empty never happens.
- When written reaches word_count, the last write has completed; go to DONE.
- Outside LOAD: wenable=0. data_in and write_address hold their last values.
- Counters are ADDR_W+1 bits wide so that word_count=2^ADDR_W is representable.

Test Plan:
- Basic load: start with base_addr=4, word_count=3; send A5C30F1E, 11, 22, 33 back-to-back -> wenable on addresses 4, 5, 6 with data 11, 22, 33; done pulses once; busy low after; key never written.
- Wrong key: start, send DEADBEEF -> key_fault=1, no wenable, host_ready=0. A later start clears key_fault and a correct key proceeds.
- Backpressure and wrap: base_addr=30, word_count=6; host sends key plus 6 words with valid gaps -> FIFO never overflows; writes go to 30, 31, 0, 1, 2, 3 in order; exactly 6 wenable pulses.
- Zero-length: start with word_count=0, key only -> done one cycle after key, no wenable.
- Reset mid-LOAD: assert reset (0) after 2 of 5 words written -> all outputs 0 immediately; no further wenable after release; state IDLE.
- Full-rate throughput: word_count=32, host_valid held high -> 32 consecutive wenable cycles; done follows the last write.
